// File: rtl/fft_pkg.sv
// Shared types, default widths and the bit-reversal helper for the FFT reorder path.
package fft_pkg;

  localparam int DEF_IDX_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    WR_FILL  = 1'b0,
    WR_STALL = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  typedef struct packed {
    wr_state_e wr;
    rd_state_e rd;
    logic      wbank;
    logic      rbank;
  } dbg_state_t;

  // Reverse the low 'width' bits of idx; width must be constant at the call site.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < width; b++) begin
      r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// One frame of sample storage plus its full flag; write and read ports are independent.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  set_full,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clear_full,
  output logic                  full
);

  localparam int IDX_SIZE = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [IDX_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IDX_SIZE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // set and clear never coincide: a full bank is not written, an empty one is not read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clear_full) begin
      full <= 1'b0;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_stream.sv
// Streaming bit-reversal reorder buffer: frames are written in bit-reversed slots and
// drained in slot order from a ping-pong pair of banks.
module fft_bitrev_stream
  import fft_pkg::*;
#(
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output dbg_state_t            dbg_state
);

  localparam logic [IDX_WIDTH-1:0] CNT_LAST = '1;

  logic [IDX_WIDTH-1:0]  wcnt, rcnt, wr_addr;
  logic                  wbank, rbank;
  logic [1:0]            full;
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  in_accept, out_accept;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and data/last are held while valid && !ready.
  assign in_ready   = !full[wbank];
  assign out_valid  = full[rbank];
  assign out_data   = rd_data[rbank];
  assign out_last   = out_valid && (rcnt == CNT_LAST);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;
  assign wr_addr    = IDX_WIDTH'(bitrev(32'(wcnt), IDX_WIDTH));

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_pingpong_bank #(
      .IDX_WIDTH  (IDX_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_addr    (wr_addr),
      .wr_data    (in_data),
      .wr_en      (in_accept && (wbank == 1'(g))),
      .set_full   (in_accept && (wbank == 1'(g)) && (wcnt == CNT_LAST)),
      .rd_addr    (rcnt),
      .rd_data    (rd_data[g]),
      .clear_full (out_accept && (rbank == 1'(g)) && (rcnt == CNT_LAST)),
      .full       (full[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (in_accept) begin
      wcnt <= wcnt + 1'b1;
      if (wcnt == CNT_LAST) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt  <= '0;
      rbank <= 1'b0;
    end else if (out_accept) begin
      rcnt <= rcnt + 1'b1;
      if (rcnt == CNT_LAST) rbank <= ~rbank;
    end
  end

  // Side states are pure decodes of the full flags.
  always_comb begin
    dbg_state       = '0;
    dbg_state.wr    = full[wbank] ? WR_STALL : WR_FILL;
    dbg_state.rd    = full[rbank] ? RD_DRAIN : RD_IDLE;
    dbg_state.wbank = wbank;
    dbg_state.rbank = rbank;
  end

endmodule

// File: tb/tb_fft_bitrev_stream.sv
// Bench for fft_bitrev_stream: frame-level reorder model checked every cycle, plus literal pins.
module tb_fft_bitrev_stream;
  import fft_pkg::*;

  localparam int W   = 5;
  localparam int N   = 32;
  localparam int DW  = 32;
  localparam int W3  = 3;
  localparam int DW3 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_data;
  dbg_state_t    dbg;

  logic           in_valid3, in_ready3, out_valid3, out_ready3, out_last3;
  logic [DW3-1:0] in_data3, out_data3;
  dbg_state_t     dbg3;

  fft_bitrev_stream #(.IDX_WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .dbg_state(dbg)
  );

  fft_bitrev_stream #(.IDX_WIDTH(W3), .DATA_WIDTH(DW3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_last(out_last3),
    .dbg_state(dbg3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  cur_q[$];
  logic [DW-1:0]  out_log[$];
  int             out_cyc[$];
  logic [DW3-1:0] out3_log[$];
  int last_pos = 0;
  int last3_pos = 0;
  int rdy_mode = 0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reverse 'w' bits by peeling them off with arithmetic.
  function automatic int model_rev(input int x, input int w);
    int r;
    r = 0;
    for (int b = 0; b < w; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Compare process: inputs change at posedge+1, so the negedge sees the handshakes
  // that complete at the next posedge.
  always @(negedge clk) begin
    int held;
    int rem;
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
    end else begin
      held = (exp_q.size() + N - 1) / N;
      check("in_ready", in_ready, held < 2);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        rem = exp_q.size() % N;
        if (rem == 0) rem = N;
        check("out_last", out_last, rem == 1);
        check("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          out_log.push_back(out_data);
          out_cyc.push_back(cyc);
          if (out_last) last_pos = out_log.size();
          void'(exp_q.pop_front());
        end
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (in_valid && in_ready) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == N) begin
          for (int m = 0; m < N; m++) exp_q.push_back(cur_q[model_rev(m, W)]);
          cur_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      out3_log.push_back(out_data3);
      if (out_last3) last3_pos = out3_log.size();
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(1) == 1);
    endcase
  end

  // Called at posedge+1; returns at posedge+1 right after the sample is accepted.
  task automatic push(input logic [DW-1:0] d, input int vpct);
    int guard;
    while ($urandom_range(99) >= vpct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) check("push_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 5000) check("drain_timeout", 1, 0);
  endtask

  // ---------------- directed sequence ----------------
  int exp3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    int guard;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame 0..31
    out_log.delete();
    for (int i = 0; i < 31; i++) push(i, 100);
    check("t1_valid_before_last", out_valid, 0);
    push(31, 100);
    check("t1_valid_after_last", out_valid, 1);
    check("t1_first_data", out_data, 0);
    wait_drain();
    check("t1_count", out_log.size(), 32);
    check("t1_out0", out_log[0], 0);
    check("t1_out1", out_log[1], 16);
    check("t1_out2", out_log[2], 8);
    check("t1_out3", out_log[3], 24);
    check("t1_out4", out_log[4], 4);
    check("t1_out8", out_log[8], 2);
    check("t1_out31", out_log[31], 31);
    check("t1_last_pos", last_pos, 32);

    // Back-to-back frames 0..95
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 96; i++) push(i, 100);
    wait_drain();
    check("t2_count", out_log.size(), 96);
    check("t2_no_gaps", out_cyc[95] - out_cyc[0], 95);
    check("t2_f2_first", out_log[32], 32);
    check("t2_f2_second", out_log[33], 48);
    check("t2_f3_last", out_log[95], 95);

    // Backpressure: both banks fill while the consumer stalls
    rdy_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) push(i, 100);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_valid", out_valid, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("t3_hold_data", out_data, 0);
    check("t3_hold_last", out_last, 0);
    check("t3_dbg_wr", dbg.wr, WR_STALL);
    check("t3_dbg_rd", dbg.rd, RD_DRAIN);
    rdy_mode = 0;
    guard = 0;
    while (exp_q.size() > 32 && guard < 200) begin
      if (exp_q.size() == 33) check("t3_ready_before_free", in_ready, 0);
      guard++;
      @(posedge clk); #1;
    end
    check("t3_ready_after_free", in_ready, 1);
    wait_drain();

    // Random in_valid / out_ready over 20 frames
    out_log.delete();
    rdy_mode = 2;
    for (int i = 0; i < 20 * N; i++) push($urandom, 60);
    wait_drain();
    rdy_mode = 0;
    check("t4_count", out_log.size(), 20 * N);
    check("t4_no_partial", cur_q.size(), 0);

    // Small-frame build
    check("t6_ready", in_ready3, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid3 = 1'b1;
      in_data3  = DW3'(i);
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("t6_count", out3_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < out3_log.size()) check("t6_order", out3_log[i], exp3[i]);
    end
    check("t6_last_pos", last3_pos, 8);

    // Reset mid-frame while the previous frame drains
    for (int i = 0; i < 32; i++) push(200 + i, 100);
    for (int i = 0; i < 10; i++) push(300 + i, 100);
    check("t5_draining", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready, 1);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_data", out_data, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_log.delete();
    for (int i = 0; i < 32; i++) push(100 + i, 100);
    wait_drain();
    check("t5_count", out_log.size(), 32);
    check("t5_out0", out_log[0], 100);
    check("t5_out1", out_log[1], 116);
    check("t5_out2", out_log[2], 108);
    check("t5_out31", out_log[31], 131);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
